sobel_window: RTL and testbench
===============================

SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 480, image height in lines (>=3).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pix_in  input  8  raster-order pixel, unsigned.
REQ-006 SHALL have port pix_valid  input  1  pix_in accepted this cycle when high; gaps allowed; no backpressure.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid; marks pixel (0,0).
REQ-008 SHALL have ports p0 p1 p2 p3 p5 p6 p7 p8  output  8 each  3x3 neighbourhood, centre excluded.
REQ-009 SHALL have port win_valid  output  1  one-cycle strobe; p0..p8 are a valid window.

Function
REQ-010 SHALL buffer the two previous lines in two IMG_W-deep line buffers, addressed by the column counter, read-before-write.
REQ-011 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) counters, advanced only on accepted pixels; col wraps to 0 and row increments at IMG_W-1.
REQ-012 SHALL, for accepted pixel (r,c), register p0=(r-2,c-2), p1=(r-2,c-1), p2=(r-2,c), p3=(r-1,c-2), p5=(r-1,c), p6=(r,c-2), p7=(r,c-1), p8=(r,c).
REQ-013 SHALL assert win_valid exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2; latency 1 clock; (IMG_W-2)*(IMG_H-2) strobes per frame.
REQ-014 SHALL hold p0..p8 between strobes; win_valid low otherwise.
REQ-015 SHALL implement FSM states IDLE, FILL, ACTIVE.
REQ-016 IDLE: ignore pixels unless sof&pix_valid; that pixel becomes (0,0), go FILL.
REQ-017 FILL (rows 0-1): write line buffers, no win_valid; go ACTIVE on accepting (1,IMG_W-1).
REQ-018 ACTIVE: produce windows; go IDLE after accepting (IMG_H-1,IMG_W-1).
REQ-019 SHALL treat sof&pix_valid in any state as restart: pixel becomes (0,0), state FILL, no window from it.
REQ-020 SHALL never mix columns across a line wrap: no win_valid for c<2.

Reset
REQ-021 SHALL on rst force state IDLE, col=row=0, win_valid=0, p0..p8=0 at the next edge, including mid-frame.
REQ-022 Line buffer contents SHALL need no reset; FILL rewrites them before use.

Configuration
REQ-023 With SOBEL_WINDOW_FRAME_CNT_EN defined, SHALL add output frame_cnt (16 bits), reset 0, incremented on the cycle after accepting (IMG_H-1,IMG_W-1), wrapping at 0xFFFF to 0.
REQ-024 Without SOBEL_WINDOW_FRAME_CNT_EN, frame_cnt and its counter SHALL not exist.

Structure
REQ-025 Package sobel_pkg SHALL hold PIX_W=8, the FSM state enum, and the col/row width function (clog2-based).
REQ-026 Sub-module sobel_line_buf SHALL implement one IMG_W x 8 read-before-write single-port buffer; instantiated twice.

Verification (IMG_W=5, IMG_H=4, pix_in = row*16+col)
REQ-027 Continuous frame with sof on first pixel -> first win_valid one cycle after pixel 0x22 with p0=00 p1=01 p2=02 p3=10 p5=12 p6=20 p7=21 p8=22; exactly 6 strobes; last window p8=0x34.
REQ-028 Same frame with random 1-3 cycle pix_valid gaps -> identical window sequence; each strobe one cycle after its accepted pixel.
REQ-029 Pixels (3,0) and (3,1) -> no win_valid; pixel (3,2) -> p6=0x30 p7=0x31 p8=0x32, p0=0x10.
REQ-030 sof reasserted at (1,3) -> counters restart; no strobe until new (2,2); window contains only new-frame data.
REQ-031 rst during row 2 -> next cycle all outputs 0, state IDLE; pixels without sof produce no strobe.
REQ-032 SOBEL_WINDOW_FRAME_CNT_EN defined, two full frames -> frame_cnt=2; undefined -> build has no frame_cnt.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel width, window FSM states and counter width helper
package sobel_pkg;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sobel_window_if.sv
// sobel_window_if: raster pixel stream in, 3x3 neighbourhood (centre excluded) out
interface sobel_window_if;
  import sobel_pkg::*;
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
  logic sof;
  logic [PIX_W-1:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic win_valid;
  modport master (output pix_in, pix_valid, sof, input p0, p1, p2, p3, p5, p6, p7, p8, win_valid);
  modport slave (input pix_in, pix_valid, sof, output p0, p1, p2, p3, p5, p6, p7, p8, win_valid);
endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of pixels, single port, old data readable in the write cycle
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  localparam int AW = cnt_w(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [PIX_W-1:0] wd,
  output logic [PIX_W-1:0] rd
);
  logic [PIX_W-1:0] mem [DEPTH];
  assign rd = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wd;
endmodule

// File: rtl/sobel_window.sv
// sobel_window: 3x3 window generator over two line buffers; SOBEL_WINDOW_FRAME_CNT_EN adds frame_cnt
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic clk,
  input logic rst,
  sobel_window_if.slave s
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
  state_t state, state_n;
  logic [CW-1:0] col, cc;
  logic [RW-1:0] row;
  logic start, acc, eol, last, strobe;
  logic [PIX_W-1:0] l1, l2, a1, a2, b1, b2, d1, d2;
  // a sof pixel is column 0 of a fresh frame in every state
  always_comb begin
    start = s.pix_valid & s.sof;
    acc = s.pix_valid & (start | (state != IDLE));
    cc = start ? '0 : col;
    eol = cc == CMAX;
    last = acc & !start & (state == ACTIVE) & eol & (row == RMAX);
    strobe = acc & !start & (state == ACTIVE) & (cc >= CW'(2));
    state_n = start ? FILL
            : (acc && state == FILL && row == RW'(1) && eol) ? ACTIVE
            : last ? IDLE
            : state;
  end
  sobel_line_buf #(.DEPTH(IMG_W)) lb1 (.clk(clk), .we(acc), .addr(cc), .wd(s.pix_in), .rd(l1));
  sobel_line_buf #(.DEPTH(IMG_W)) lb2 (.clk(clk), .we(acc), .addr(cc), .wd(l1), .rd(l2));
  // a*/b*/d* hold columns c-1,c-2 of rows r, r-1, r-2
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      s.win_valid <= 1'b0;
      {s.p0, s.p1, s.p2, s.p3, s.p5, s.p6, s.p7, s.p8} <= '0;
    end else begin
      state <= state_n;
      s.win_valid <= strobe;
      if (acc) begin
        col <= eol ? '0 : cc + 1'b1;
        row <= start ? '0 : eol ? ((row == RMAX) ? '0 : row + 1'b1) : row;
        {a2, a1} <= {a1, s.pix_in};
        {b2, b1} <= {b1, l1};
        {d2, d1} <= {d1, l2};
      end
      if (strobe) {s.p0, s.p1, s.p2, s.p3, s.p5, s.p6, s.p7, s.p8} <= {d2, d1, l2, b2, l1, a2, a1, s.pix_in};
    end
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
  always_ff @(posedge clk)
    if (rst) frame_cnt <= '0;
    else if (last) frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: table-driven check of sobel_window on a 5x4 image with pixel = row*16+col
module tb_sobel_window;
  import sobel_pkg::*;
  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;
  typedef struct {
    logic s;
    logic [7:0] px;
    logic ewv;
    logic [63:0] ew;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sobel_window_if bus();
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  sobel_window #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst(rst),
    .s(bus)
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  vec_t frm [N];
  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [63:0] held = '0;
  logic [63:0] win;
  assign win = {bus.p0, bus.p1, bus.p2, bus.p3, bus.p5, bus.p6, bus.p7, bus.p8};
  function automatic logic [7:0] pv(input int r, input int c, input logic [7:0] b);
    return b | 8'(r * 16 + c);
  endfunction
  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      frm[i].s = (i == 0);
      frm[i].px = pv(r, c, b);
      frm[i].ewv = (r >= 2) && (c >= 2);
      frm[i].ew = {pv(r-2, c-2, b), pv(r-2, c-1, b), pv(r-2, c, b), pv(r-1, c-2, b),
                   pv(r-1, c, b), pv(r, c-2, b), pv(r, c-1, b), pv(r, c, b)};
    end
  endtask
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic s, input logic r, input logic [7:0] px,
                      input logic ewv, input logic [63:0] ew, input string nm);
    rst = r;
    bus.pix_valid = v;
    bus.sof = s;
    bus.pix_in = px;
    @(posedge clk);
    #1;
    if (r) held = '0;
    else if (ewv) held = ew;
    if (bus.win_valid) strobes++;
    check({nm, " wv"}, 64'(bus.win_valid), 64'(ewv));
    check({nm, " win"}, win, held);
  endtask
  task automatic run_frame(input bit gaps, input string nm);
    strobes = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0, 8'hee, 1'b0, '0, {nm, " gap"});
      step(1'b1, frm[i].s, 1'b0, frm[i].px, frm[i].ewv, frm[i].ew, $sformatf("%s px%0d", nm, i));
    end
    check({nm, " strobes"}, 64'(strobes), 64'((W - 2) * (H - 2)));
    check({nm, " last p8"}, 64'(win[7:0]), 64'(frm[N-1].px));
  endtask
  initial begin
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pix_in = '0;
    repeat (2) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, '0, "reset");
    fill(8'h00);
    run_frame(1'b0, "cont");
    run_frame(1'b1, "gaps");
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
    check("frame_cnt two", 64'(frame_cnt), 64'd2);
`endif
    for (int i = 0; i < 8; i++) step(1'b1, frm[i].s, 1'b0, frm[i].px, 1'b0, '0, "pre restart");
    fill(8'h80);
    run_frame(1'b0, "restart");
    fill(8'h00);
    for (int i = 0; i < 13; i++) step(1'b1, frm[i].s, 1'b0, frm[i].px, frm[i].ewv, frm[i].ew, "row2");
    step(1'b1, 1'b0, 1'b1, frm[13].px, 1'b0, '0, "rst mid");
    check("rst state", 64'(dut.state), 64'(IDLE));
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
    check("frame_cnt rst", 64'(frame_cnt), 64'd0);
`endif
    for (int i = 14; i < N; i++) step(1'b1, 1'b0, 1'b0, frm[i].px, 1'b0, '0, "no sof");
    check("idle state", 64'(dut.state), 64'(IDLE));
    run_frame(1'b0, "recover");
`ifdef SOBEL_WINDOW_FRAME_CNT_EN
    check("frame_cnt one", 64'(frame_cnt), 64'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
